lfsr_rand_server: RTL and testbench

- Shares one XNOR-feedback LFSR among NUM_REQ game-logic requesters (spawn positions, enemy timing, etc.).
- Arbitrates requests round-robin and steps the LFSR on demand.
- Reduces each random word to a per-requester bound `[0, limit)` by masked rejection sampling with a bounded retry count.
- Sits between the game FSMs and the randomness source; no requester drives the LFSR directly.

---
 rtl/lfsr_rand_server.sv | 173 +++++++++++++++++
 tb/tb_lfsr_rand_server.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_rand_server.sv
// Round-robin server sharing one XNOR-feedback LFSR; bounds each result to [0, limit) by masked rejection sampling.
// Define LFSR_RAND_AUTO_SEED_EN to seed from a free-running counter on the first grant after reset.
`timescale 1ns/1ps
module lfsr_rand_server #(
  parameter int NUM_REQ   = 4,
  parameter int NUM_BITS  = 11,
  parameter int MAX_TRIES = 8
) (
  input  logic                         i_Clk,
  input  logic                         i_Rst,
  input  logic [NUM_REQ-1:0]           i_Req,
  input  logic [NUM_REQ*NUM_BITS-1:0]  i_Limit,
  input  logic                         i_Seed_DV,
  input  logic [NUM_BITS-1:0]          i_Seed_Data,
  output logic [NUM_REQ-1:0]           o_Gnt,
  output logic [NUM_BITS-1:0]          o_Data,
  output logic                         o_Busy
);

  localparam int IW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {IDLE, STEP, CHECK} state_t;

  state_t                state_q, state_d;
  logic [NUM_BITS-1:0]   lfsr_q, lfsr_d;
  logic [IW-1:0]         ptr_q, ptr_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [NUM_BITS-1:0]   lim_q, lim_d;
  logic [3:0]            tries_q, tries_d;
  logic [NUM_REQ-1:0]    gnt_q, gnt_d;
  logic [NUM_BITS-1:0]   data_q, data_d;

  logic                  fb;
  logic                  found;
  logic [IW-1:0]         pick;
  logic [NUM_BITS-1:0]   mask;
  logic [NUM_BITS-1:0]   cand;
  logic                  accept;

  function automatic logic [NUM_BITS-1:0] no_lockup(input logic [NUM_BITS-1:0] v);
    return (&v) ? '0 : v;
  endfunction

  // Fill every bit below the leading one: smallest 2^k-1 covering v.
  function automatic logic [NUM_BITS-1:0] smear(input logic [NUM_BITS-1:0] v);
    logic [NUM_BITS-1:0] m;
    m = v;
    for (int i = 0; i < NUM_BITS; i++) m = m | (m >> 1);
    return m;
  endfunction

  generate
    if (NUM_BITS == 8) begin : g_fb8
      assign fb = lfsr_q[7] ~^ lfsr_q[5] ~^ lfsr_q[4] ~^ lfsr_q[3];
    end else if (NUM_BITS == 16) begin : g_fb16
      assign fb = lfsr_q[15] ~^ lfsr_q[14] ~^ lfsr_q[12] ~^ lfsr_q[3];
    end else begin : g_fb11
      assign fb = lfsr_q[10] ~^ lfsr_q[8];
    end
  endgenerate

`ifdef LFSR_RAND_AUTO_SEED_EN
  logic [NUM_BITS-1:0] cnt_q;
  logic                seeded_q, seeded_d;

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      cnt_q    <= '0;
      seeded_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_q + 1'b1;
      seeded_q <= seeded_d;
    end
  end
`endif

  always_comb begin
    int j;
    found = 1'b0;
    pick  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      j = int'(ptr_q) + i;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!found && i_Req[IW'(j)]) begin
        found = 1'b1;
        pick  = IW'(j);
      end
    end
  end

  assign mask   = smear(lim_q - 1'b1);
  assign cand   = lfsr_q & mask;
  assign accept = (lim_q == '0) || (cand < lim_q);

  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    lim_d   = lim_q;
    tries_d = tries_q;
    gnt_d   = '0;
    data_d  = data_q;
`ifdef LFSR_RAND_AUTO_SEED_EN
    seeded_d = seeded_q;
`endif
    case (state_q)
      IDLE: begin
        if (i_Seed_DV) begin
          lfsr_d = no_lockup(i_Seed_Data);
`ifdef LFSR_RAND_AUTO_SEED_EN
          seeded_d = 1'b1;
`endif
        end else if (found) begin
          idx_d   = pick;
          lim_d   = i_Limit[pick*NUM_BITS +: NUM_BITS];
          tries_d = '0;
          state_d = STEP;
`ifdef LFSR_RAND_AUTO_SEED_EN
          if (!seeded_q) begin
            lfsr_d   = no_lockup(cnt_q);
            seeded_d = 1'b1;
          end
`endif
        end
      end
      STEP: begin
        lfsr_d  = {lfsr_q[NUM_BITS-2:0], fb};
        tries_d = tries_q + 1'b1;
        state_d = CHECK;
      end
      CHECK: begin
        // Out of tries: cand - L is below L because cand <= mask < 2L-1.
        if (accept || (tries_q == 4'(MAX_TRIES))) begin
          data_d  = accept ? cand : cand - lim_q;
          gnt_d   = NUM_REQ'(1) << idx_q;
          ptr_d   = (idx_q == IW'(NUM_REQ-1)) ? '0 : idx_q + 1'b1;
          state_d = IDLE;
        end else begin
          state_d = STEP;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state_q <= IDLE;
      lfsr_q  <= '0;
      ptr_q   <= '0;
      idx_q   <= '0;
      lim_q   <= '0;
      tries_q <= '0;
      gnt_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      lim_q   <= lim_d;
      tries_q <= tries_d;
      gnt_q   <= gnt_d;
      data_q  <= data_d;
    end
  end

  assign o_Gnt  = gnt_q;
  assign o_Data = data_q;
  assign o_Busy = (state_q != IDLE);

endmodule

// File: tb/tb_lfsr_rand_server.sv
// Scoreboarded bench for lfsr_rand_server: reference model predicts grant order, data and latency.
`timescale 1ns/1ps
module tb_lfsr_rand_server;

  localparam int NR = 4;
  localparam int NB = 11;
  localparam int MT = 8;
  localparam int ALL1 = (1 << NB) - 1;

  logic              clk = 1'b0;
  logic              rst;
  logic [NR-1:0]     i_Req;
  logic [NR*NB-1:0]  i_Limit;
  logic              i_Seed_DV;
  logic [NB-1:0]     i_Seed_Data;
  logic [NR-1:0]     o_Gnt;
  logic [NB-1:0]     o_Data;
  logic              o_Busy;

  lfsr_rand_server #(.NUM_REQ(NR), .NUM_BITS(NB), .MAX_TRIES(MT)) dut (
    .i_Clk(clk), .i_Rst(rst), .i_Req(i_Req), .i_Limit(i_Limit),
    .i_Seed_DV(i_Seed_DV), .i_Seed_Data(i_Seed_Data),
    .o_Gnt(o_Gnt), .o_Data(o_Data), .o_Busy(o_Busy)
  );

  always #5 clk = ~clk;

  typedef struct {int gnt; int data; int lat;} exp_t;
  exp_t sb[$];

  int tests = 0;
  int fails = 0;
  int m_lfsr = 0;
  int m_ptr  = 0;
  int lim_arr[NR];
  int busy_cnt = 0;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int bit_of(input int s, input int k);
    return (s >> (k - 1)) & 1;
  endfunction

  // Feedback = inverted parity of the tap bits (chained XNOR).
  function automatic int model_step(input int s);
    int par;
    if (NB == 8)       par = bit_of(s,8) ^ bit_of(s,6) ^ bit_of(s,5) ^ bit_of(s,4);
    else if (NB == 16) par = bit_of(s,16) ^ bit_of(s,15) ^ bit_of(s,13) ^ bit_of(s,4);
    else               par = bit_of(s,11) ^ bit_of(s,9);
    return ((s << 1) | (1 - par)) & ALL1;
  endfunction

  task automatic model_serve(input int k, input int lim);
    int t, m, c, d;
    exp_t e;
    t = 0;
    d = 0;
    while (1) begin
      m_lfsr = model_step(m_lfsr);
      t++;
      if (lim == 0) m = ALL1;
      else begin
        m = 0;
        while (m < lim - 1) m = m * 2 + 1;
      end
      c = m_lfsr & m;
      if (lim == 0 || c < lim) begin d = c; break; end
      if (t == MT) begin d = c - lim; break; end
    end
    e.gnt = 1 << k; e.data = d; e.lat = 2 * t;
    sb.push_back(e);
    m_ptr = (k + 1) % NR;
  endtask

  task automatic model_round(input int mask);
    int pend;
    bit done;
    pend = mask;
    while (pend != 0) begin
      done = 1'b0;
      for (int i = 0; i < NR; i++) begin
        int j;
        j = (m_ptr + i) % NR;
        if (!done && ((pend >> j) & 1) != 0) begin
          model_serve(j, lim_arr[j]);
          pend = pend & ~(1 << j);
          done = 1'b1;
        end
      end
    end
  endtask

  task automatic drive_limits();
    for (int k = 0; k < NR; k++) i_Limit[k*NB +: NB] = NB'(lim_arr[k]);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    i_Req = '0;
    i_Seed_DV = 1'b0;
    #1;
    check("rst_gnt", int'(o_Gnt), 0);
    check("rst_data", int'(o_Data), 0);
    check("rst_busy", int'(o_Busy), 0);
    m_lfsr = 0;
    m_ptr = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Holds each requester until its grant; seed may share the request cycle or land during STEP.
  task automatic run_round(input int mask, input bit with_seed, input int seed,
                           input bit mid_seed, input bit mid_lim);
    logic [NR-1:0] pend;
    int cyc;
    @(negedge clk);
    drive_limits();
    i_Req = NR'(mask);
    if (with_seed) begin
      i_Seed_DV = 1'b1;
      i_Seed_Data = NB'(seed);
      m_lfsr = (seed == ALL1) ? 0 : seed;
    end
    model_round(mask);
    pend = NR'(mask);
    cyc = 0;
    while (pend != '0 && cyc < 600) begin
      @(negedge clk);
      i_Seed_DV = mid_seed && (cyc == 0);
      if (i_Seed_DV) i_Seed_Data = NB'($urandom_range(0, ALL1));
      if (mid_lim && cyc == 0) begin
        for (int k = 0; k < NR; k++) i_Limit[k*NB +: NB] = NB'(1);
      end
      cyc++;
      pend  = pend & ~o_Gnt;
      i_Req = i_Req & ~o_Gnt;
    end
    i_Seed_DV = 1'b0;
    check("round_done", int'(pend), 0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) busy_cnt = 0;
      else if (o_Gnt != '0) begin
        if (sb.size() == 0) begin
          check("unexpected_gnt", int'(o_Gnt), 0);
        end else begin
          e = sb.pop_front();
          check("gnt", int'(o_Gnt), e.gnt);
          check("data", int'(o_Data), e.data);
          check("latency", busy_cnt, e.lat);
          check("busy_at_gnt", int'(o_Busy), 0);
        end
        busy_cnt = 0;
      end else if (o_Busy) busy_cnt++;
      else busy_cnt = 0;
    end
  end

  initial begin : stim
    int mask, sel, seed;
    bit ws, ms;
    rst = 1'b1;
    i_Req = '0;
    i_Limit = '0;
    i_Seed_DV = 1'b0;
    i_Seed_Data = '0;
    for (int k = 0; k < NR; k++) lim_arr[k] = 0;

    do_reset();
    repeat (3) run_round(1, 0, 0, 0, 0);

    do_reset();
    run_round(15, 0, 0, 0, 0);
    run_round(1, 0, 0, 0, 0);

    lim_arr[0] = 3;
    run_round(1, 1, 1, 0, 0);

    do_reset();
    lim_arr[0] = 0;
    lim_arr[1] = 5;
    run_round(2, 0, 0, 0, 1);

    for (int k = 0; k < NR; k++) lim_arr[k] = 0;
    run_round(4, 1, ALL1, 0, 0);
    run_round(4, 0, 0, 1, 0);

    // Abort a rejection loop from inside CHECK.
    lim_arr[0] = 3;
    @(negedge clk);
    drive_limits();
    i_Seed_DV = 1'b1;
    i_Seed_Data = NB'(1);
    @(negedge clk);
    i_Seed_DV = 1'b0;
    i_Req = NR'(1);
    repeat (4) @(negedge clk);
    i_Req = '0;
    check("busy_before_abort", int'(o_Busy), 1);
    rst = 1'b1;
    #1;
    check("abort_gnt", int'(o_Gnt), 0);
    check("abort_data", int'(o_Data), 0);
    check("abort_busy", int'(o_Busy), 0);
    m_lfsr = 0;
    m_ptr = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    lim_arr[0] = 0;
    run_round(1, 0, 0, 0, 0);

    for (int r = 0; r < 40; r++) begin
      mask = $urandom_range(1, (1 << NR) - 1);
      for (int k = 0; k < NR; k++) begin
        sel = $urandom_range(0, 3);
        case (sel)
          0: lim_arr[k] = 0;
          1: lim_arr[k] = 1;
          2: lim_arr[k] = $urandom_range(2, 40);
          default: lim_arr[k] = $urandom_range(41, ALL1);
        endcase
      end
      ws = ($urandom_range(0, 3) == 0);
      seed = ($urandom_range(0, 4) == 0) ? ALL1 : $urandom_range(0, ALL1);
      ms = !ws && ($urandom_range(0, 2) == 0);
      run_round(mask, ws, seed, ms, 0);
    end

    repeat (4) @(negedge clk);
    check("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
